// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with hazard scoreboard and flush
module decode_stage #(
    parameter int REG_AW = 3,
    parameter int DATA_W = 8,
    localparam int IW    = 7 + 3 * REG_AW,
    localparam int NREG  = 2 ** REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IW-1:0]     in_ir,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] da,
    output logic [REG_AW-1:0] aa,
    output logic [REG_AW-1:0] ba,
    output logic [3:0]        fs,
    output logic              mb,
    output logic              md,
    output logic              rw,
    output logic              mw,
    output logic              pl,
    output logic              jb,
    output logic              bc,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] offs
);

    // Fields of the incoming instruction
    logic [6:0]        op_new;
    logic [REG_AW-1:0] da_new;
    logic [REG_AW-1:0] aa_new;
    logic [REG_AW-1:0] ba_new;

    // Decoded control word for the incoming instruction
    logic [3:0]        fs_new;
    logic              mb_new;
    logic              md_new;
    logic              rw_new;
    logic              mw_new;
    logic              pl_new;
    logic              jb_new;
    logic              bc_new;
    logic [DATA_W-1:0] imm_new;
    logic [DATA_W-1:0] offs_new;

    // Registers with a write in flight (handed off downstream, not yet retired)
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pend_set;
    logic [NREG-1:0]   pend_clr;

    logic              held_wr;
    logic              hazard;
    logic              accept;
    logic              handoff;

    assign op_new = in_ir[IW-1:IW-7];
    assign da_new = in_ir[3*REG_AW-1:2*REG_AW];
    assign aa_new = in_ir[2*REG_AW-1:REG_AW];
    assign ba_new = in_ir[REG_AW-1:0];

    // Control-word decode of the incoming opcode
    always_comb begin
        mb_new   = op_new[6];
        md_new   = op_new[4];
        jb_new   = op_new[4];
        rw_new   = ~op_new[5];
        bc_new   = op_new[0];
        mw_new   = op_new[5] & ~op_new[6];
        pl_new   = op_new[5] & op_new[6];
        fs_new   = {op_new[3:1], ~pl_new & op_new[0]};
        imm_new  = DATA_W'(ba_new);
        offs_new = DATA_W'($signed({da_new, ba_new}));
    end

    // RAW/WAW check against the scoreboard and against the word still held here;
    // a B-field that is an immediate (mb=1) is not a register read
    always_comb begin
        held_wr = out_valid & rw;
        hazard  = 1'b0;
        if (pending[aa_new] || (held_wr && (da == aa_new))) begin
            hazard = 1'b1;
        end
        if (!mb_new && (pending[ba_new] || (held_wr && (da == ba_new)))) begin
            hazard = 1'b1;
        end
        if (rw_new && (pending[da_new] || (held_wr && (da == da_new)))) begin
            hazard = 1'b1;
        end
    end

    assign handoff  = out_valid & out_ready;
    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // Scoreboard set/clear vectors; a handed-off register write marks its destination busy
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (handoff && rw) begin
            pend_set[da] = 1'b1;
        end
        if (wb_valid) begin
            pend_clr[wb_addr] = 1'b1;
        end
    end

    // Scoreboard register; set beats clear on the same register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    // Output valid: load on accept, drop on handoff or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (handoff || flush) begin
            out_valid <= 1'b0;
        end
    end

    // Output word register; only changes on accept so it holds under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            da   <= '0;
            aa   <= '0;
            ba   <= '0;
            fs   <= '0;
            mb   <= 1'b0;
            md   <= 1'b0;
            rw   <= 1'b0;
            mw   <= 1'b0;
            pl   <= 1'b0;
            jb   <= 1'b0;
            bc   <= 1'b0;
            imm  <= '0;
            offs <= '0;
        end else if (accept) begin
            da   <= da_new;
            aa   <= aa_new;
            ba   <= ba_new;
            fs   <= fs_new;
            mb   <= mb_new;
            md   <= md_new;
            rw   <= rw_new;
            mw   <= mw_new;
            pl   <= pl_new;
            jb   <= jb_new;
            bc   <= bc_new;
            imm  <= imm_new;
            offs <= offs_new;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    typedef struct {
        logic [2:0] da, aa, ba;
        logic [3:0] fs;
        logic       mb, md, rw, mw, pl, jb, bc;
        logic [7:0] imm, offs;
    } dec_t;

    typedef struct {
        logic [15:0] ir;
        dec_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, flush, wb_valid, out_valid, out_ready;
    logic [15:0] in_ir;
    logic [2:0]  wb_addr, da, aa, ba;
    logic [3:0]  fs;
    logic        mb, md, rw, mw, pl, jb, bc;
    logic [7:0]  imm, offs;

    int n_checks = 0;
    int n_err    = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
        .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .out_valid(out_valid),
        .out_ready(out_ready), .da(da), .aa(aa), .ba(ba), .fs(fs), .mb(mb), .md(md),
        .rw(rw), .mw(mw), .pl(pl), .jb(jb), .bc(bc), .imm(imm), .offs(offs)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string tag, input dec_t e);
        check({tag, ".da"},   32'(da),   32'(e.da));
        check({tag, ".aa"},   32'(aa),   32'(e.aa));
        check({tag, ".ba"},   32'(ba),   32'(e.ba));
        check({tag, ".fs"},   32'(fs),   32'(e.fs));
        check({tag, ".ctl"},  32'({mb, md, rw, mw, pl, jb, bc}),
                              32'({e.mb, e.md, e.rw, e.mw, e.pl, e.jb, e.bc}));
        check({tag, ".imm"},  32'(imm),  32'(e.imm));
        check({tag, ".offs"}, 32'(offs), 32'(e.offs));
    endtask

    // Reference decode straight from the instruction-format rules
    function automatic dec_t ref_decode(input logic [15:0] ir);
        dec_t       d;
        logic [6:0] op;
        op     = ir[15:9];
        d.da   = ir[8:6];
        d.aa   = ir[5:3];
        d.ba   = ir[2:0];
        d.mb   = op[6];
        d.md   = op[4];
        d.jb   = op[4];
        d.rw   = !op[5];
        d.bc   = op[0];
        d.mw   = op[5] && !op[6];
        d.pl   = op[5] && op[6];
        d.fs   = {op[3:1], !d.pl && op[0]};
        d.imm  = 8'(ir[2:0]);
        d.offs = 8'($signed({ir[8:6], ir[2:0]}));
        return d;
    endfunction

    // Model state: what is held at the output and which registers are busy
    bit       m_valid;
    dec_t     m_held;
    bit [7:0] m_pend;

    function automatic bit ref_blocked(input dec_t n);
        bit [7:0] busy;
        busy = m_pend;
        if (m_valid && m_held.rw) busy[m_held.da] = 1'b1;
        return busy[n.aa] || (!n.mb && busy[n.ba]) || (n.rw && busy[n.da]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_addr = '0; out_ready = 1'b1;
    endtask

    vec_t tbl[6];

    initial begin
        bit   exp_ready, hand, acc;
        dec_t nd;

        rst = 1'b1; in_valid = 1'b0; in_ir = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; out_ready = 1'b1;

        //            ir        da    aa    ba    fs       mb    md    rw    mw    pl    jb    bc    imm    offs
        tbl[0] = '{16'h0453, '{3'd1, 3'd2, 3'd3, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h0B}};
        tbl[1] = '{16'hC1D6, '{3'd7, 3'd2, 3'd6, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 8'hFE}};
        tbl[2] = '{16'h4162, '{3'd5, 3'd4, 3'd2, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'hEA}};
        tbl[3] = '{16'hBEF1, '{3'd3, 3'd6, 3'd1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h19}};
        tbl[4] = '{16'hFE07, '{3'd0, 3'd0, 3'd7, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 8'h07}};
        tbl[5] = '{16'h03FF, '{3'd7, 3'd7, 3'd7, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'hFF}};

        #12;
        rst = 1'b0;
        #1;
        check("reset.out_valid", 32'(out_valid), 0);
        check("reset.in_ready", 32'(in_ready), 1);
        check_word("reset", '{3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});

        // Decode table, one instruction after a fresh reset each
        foreach (tbl[i]) begin
            pulse_rst();
            in_ir = tbl[i].ir; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 1);
            check_word($sformatf("tbl%0d", i), tbl[i].exp);
            step();
            check($sformatf("tbl%0d.drain", i), 32'(out_valid), 0);
        end

        // RAW stall until writeback, no same-cycle bypass
        pulse_rst();
        in_ir = 16'h0453; in_valid = 1'b1;
        step();
        in_ir = 16'h048B;
        #1 check("raw.held", 32'(in_ready), 0);
        step();
        check("raw.handoff_valid", 32'(out_valid), 0);
        check("raw.pending", 32'(in_ready), 0);
        wb_valid = 1'b1; wb_addr = 3'd1;
        #1 check("raw.no_bypass", 32'(in_ready), 0);
        step();
        wb_valid = 1'b0;
        #1 check("raw.cleared", 32'(in_ready), 1);
        step();
        check("raw.accept", 32'(out_valid), 1);
        check("raw.da", 32'(da), 2);
        check("raw.aa", 32'(aa), 1);

        // Backpressure: frozen outputs, then handoff and load on one edge
        pulse_rst();
        in_ir = 16'h0453; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_ir = 16'h4162;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp.in_ready", 32'(in_ready), 0);
            step();
            check("bp.out_valid", 32'(out_valid), 1);
            check_word("bp.frozen", tbl[0].exp);
        end
        out_ready = 1'b1;
        #1 check("bp.release", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp.reload_valid", 32'(out_valid), 1);
        check_word("bp.reload", tbl[2].exp);
        in_ir = 16'h048B;
        #1 check("bp.pset", 32'(in_ready), 0);

        // Flush squashes the held word without marking it pending
        pulse_rst();
        in_ir = 16'h0453; in_valid = 1'b1; out_ready = 1'b0;
        step();
        flush = 1'b1;
        #1 check("flush.in_ready", 32'(in_ready), 0);
        step();
        flush = 1'b0;
        check("flush.out_valid", 32'(out_valid), 0);
        in_ir = 16'h048B;
        #1 check("flush.no_pset", 32'(in_ready), 1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        in_ir = 16'h4162;
        #1 check("imm.reg_b_stalls", 32'(in_ready), 0);
        in_ir = 16'hC1DA;
        #1 check("imm.mb_no_stall", 32'(in_ready), 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("imm.out_valid", 32'(out_valid), 1);
        check("imm.ctl", 32'({mb, pl, rw, ba}), 32'({1'b1, 1'b1, 1'b0, 3'd2}));
        step();
        in_ir = 16'h0038;
        #1 check("pl.no_pset", 32'(in_ready), 1);

        // Flush coinciding with handoff: the handoff still marks its destination
        pulse_rst();
        in_ir = 16'h0453; in_valid = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_ho.out_valid", 32'(out_valid), 0);
        in_ir = 16'h048B;
        #1 check("flush_ho.pset", 32'(in_ready), 0);

        // Set wins over a same-cycle clear of the same register
        pulse_rst();
        in_ir = 16'h0453; in_valid = 1'b1;
        step();
        in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 3'd1;
        step();
        wb_valid = 1'b0;
        in_ir = 16'h048B;
        #1 check("set_wins", 32'(in_ready), 0);

        // Asynchronous reset in the middle of a stall
        pulse_rst();
        in_ir = 16'h0453; in_valid = 1'b1;
        step();
        in_ir = 16'h4162;
        step();
        out_ready = 1'b0; in_ir = 16'h048B;
        #1 check("rst_mid.stalled", 32'(in_ready), 0);
        check("rst_mid.held", 32'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.out_valid", 32'(out_valid), 0);
        check_word("rst_mid", '{3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        #1 rst = 1'b0;
        #1 check("rst_mid.p_cleared", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("rst_mid.accept", 32'(out_valid), 1);
        check("rst_mid.da", 32'(da), 2);

        // Randomised traffic against the reference model
        pulse_rst();
        m_valid = 1'b0;
        m_pend  = '0;
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_addr   = 3'($urandom_range(0, 7));
            in_ir     = 16'($urandom);
            #3;
            nd        = ref_decode(in_ir);
            exp_ready = (!m_valid || out_ready) && !ref_blocked(nd) && !flush;
            check("rnd.in_ready", 32'(in_ready), 32'(exp_ready));
            check("rnd.out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) check_word("rnd", m_held);
            hand = m_valid && out_ready;
            acc  = in_valid && exp_ready;
            @(posedge clk);
            if (wb_valid) m_pend[wb_addr] = 1'b0;
            if (hand && m_held.rw) m_pend[m_held.da] = 1'b1;
            if (acc) begin
                m_valid = 1'b1;
                m_held  = nd;
            end else if (hand || flush) begin
                m_valid = 1'b0;
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage for the single-cycle/pipelined datapath.
- Decodes the 7-bit opcode and three register-address fields into datapath control words: DA, AA, BA, FS, MB, MD, RW, MW, PL, JB, BC.
- Adds what the purely combinational decoder lacks:
  - valid/ready handshake on both sides;
  - immediate and branch-offset generation;
  - a per-register write-pending scoreboard that stalls on RAW/WAW hazards;
  - a flush input.

Parameters:
- REG_AW, 3, register address width; instruction width IW = 7 + 3*REG_AW (16 at default).
- DATA_W, 8, width of the imm and offs outputs; must be >= 2*REG_AW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  instruction available.
- in_ready  out  1  stage accepts in_ir this cycle.
- in_ir  in  IW  instruction word.
- flush  in  1  squash the held instruction and block intake this cycle.
- wb_valid  in  1  a register write retires this cycle.
- wb_addr  in  REG_AW  register being written back.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  downstream accepts the decoded word.
- da, aa, ba  out  REG_AW each  destination, A source and B source addresses.
- fs  out  4  function select.
- mb, md, rw, mw, pl, jb, bc  out  1 each  control bits.
- imm  out  DATA_W  ba zero-extended.
- offs  out  DATA_W  {da,ba} sign-extended.

Behaviour:
- Field split: op = in_ir[IW-1:IW-7]; da = [3*REG_AW-1:2*REG_AW]; aa = [2*REG_AW-1:REG_AW]; ba = [REG_AW-1:0].
- Opcode bits are numbered op[6] (MSB) down to op[0].
- Decode equations:
  - mb = op[6]; md = jb = op[4]; rw = ~op[5]; bc = op[0].
  - mw = op[5] & ~op[6]; pl = op[5] & op[6].
  - fs[3:1] = op[3:1]; fs[0] = ~pl & op[0].
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N; all outputs are registered.
- Hold: while out_valid && !out_ready, every output is held stable.
- Handoff occurs when out_valid && out_ready at a rising edge.
- Hazard, evaluated combinationally on in_ir. Let P = pending bitmap; let H = out_valid && out rw (the instruction currently held). hazard is true if any of these holds:
  - P[aa], or H && da_held == aa.
  - mb == 0 and (P[ba] or H && da_held == ba).
  - rw_new and (P[da] or H && da_held == da).
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept occurs when in_valid && in_ready. On accept, the output register loads the decoded word and out_valid = 1.
- If there is no accept and a handoff occurs, out_valid = 0.
- Scoreboard (2^REG_AW bits):
  - On handoff with rw = 1, set P[da].
  - On wb_valid, clear P[wb_addr].
  - If set and clear hit the same register in the same cycle, set wins.
  - A clear becomes visible to the hazard check the cycle after wb_valid; there is no same-cycle bypass.
- Flush:
  - The output register clears out_valid at the edge; the held instruction never sets P unless a handoff happened that same cycle.
  - A handoff in the same cycle still completes and sets P.
  - No intake that cycle.
  - P is not cleared by flush.
- mw = 1 or pl = 1 instructions (rw = 0) never set P.
- Reset (asynchronous, any time, including mid-stall): out_valid = 0; da, aa, ba, fs, imm, offs = 0; mb, md, rw, mw, pl, jb, bc = 0; P = 0.
- After reset is released, in_ready = 1 as long as flush = 0.

Test Plan:
- Decode ADD: in_ir = 0x0453 -> next cycle out_valid = 1, da = 1, aa = 2, ba = 3, fs = 0010, rw = 1, mb = md = mw = pl = jb = bc = 0, imm = 0x03.
- Branch: in_ir = 0xC1D6 -> pl = 1, mb = 1, rw = 0, mw = 0, jb = 0, fs = 0000, offs = 0xFE, imm = 0x06; P unchanged after handoff.
- RAW stall: handoff 0x0453 (sets P[1]), then present 0x048B -> in_ready = 0. Pulse wb_valid with wb_addr = 1 -> in_ready = 1 the following cycle, then accept.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> outputs frozen, in_ready = 0. Raise out_ready -> handoff, new word loads on the same edge.
- Flush/immediate: hold 0x0453 with out_ready = 0, assert flush -> out_valid = 0 next cycle, P[1] = 0. Then an MB = 1 instruction whose ba equals a pending register is accepted without stall.
- Reset mid-stall: P[1] = 1, out_valid = 1, assert rst asynchronously -> all outputs 0 and P = 0 immediately; 0x048B is accepted on the first edge after release.
